// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, default timing and leading-zero helper for the display scan controller
//
// Contents:
//   nibble_t          one hex digit as presented to the segment decoder
//   DEF_*             default timing constants for display_scan_ctrl
//   MAX_DIGITS        widest digit count lzs_mask can handle
//   lzs_mask()        per-digit leading-zero suppression vector
package display_pkg;

  typedef logic [3:0] nibble_t;

  localparam int DEF_N_DIGITS     = 4;
  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_BLANK_CYCLES = 500;

  localparam int MAX_DIGITS = 16;

  // Bit k is set when digit k and every digit above it hold zero and
  // suppression is enabled. Digit 0 always stays visible so a zero value
  // still shows a single "0". Only the lowest n_digits bits are meaningful.
  function automatic logic [MAX_DIGITS-1:0] lzs_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input logic                    lzs_en,
    input int                      n_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < n_digits) begin
        zero_above = zero_above && (value[4*k +: 4] == 4'h0);
        mask[k]    = lzs_en && zero_above;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - slot counter and digit index for the multiplexed display scan
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   index       digit currently being scanned (0 = least significant)
//   in_blank    high during the first BLANK_CYCLES cycles of every slot
//   frame_tick  high on the last cycle of the last slot of a frame
module scan_timer
  import display_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int IW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] index,
  output logic          in_blank,
  output logic          frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] count;
  logic          slot_end;

  assign slot_end = (count == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      index <= '0;
    end else if (slot_end) begin
      count <= '0;
      index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

  // A zero-length blank window would make the compare constant, so it is
  // resolved at elaboration instead.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (count < BLANK_END);
    end
  endgenerate

  assign frame_tick = slot_end && (index == IDX_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-multiplexed 7-segment scan controller with frame-synchronous updates
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  update request from the application
//   load_ready  pending slot empty; transfer on load_valid && load_ready
//   load_value  nibble k in bits [4k+3:4k] is shown on digit k
//   load_blank  per-digit force-blank mask, latched with load_value
//   lzs_en      leading-zero suppression enable, used live
//   nibble      to decoder inputs {i1,i2,i3,i4}
//   digit_en    one-hot (or zero) active-high digit select
//   frame_tick  one-cycle pulse on the last cycle of each frame
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_value,
  input  logic [N_DIGITS-1:0]   load_blank,
  input  logic                  lzs_en,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_tick
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] active_value;
  logic [N_DIGITS-1:0]   active_blank;
  logic [4*N_DIGITS-1:0] pending_value;
  logic [N_DIGITS-1:0]   pending_blank;
  logic                  pending_valid;

  logic [IW-1:0]         index;
  logic                  in_blank;
  logic                  accept;
  logic                  swap;
  logic [N_DIGITS-1:0]   suppress;
  logic [4*MAX_DIGITS-1:0] value_ext;
  nibble_t               cur_nibble;

  scan_timer #(
    .N_DIGITS     (N_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IW           (IW)
  ) u_scan_timer (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .in_blank   (in_blank),
    .frame_tick (frame_tick)
  );

  assign load_ready = !pending_valid;
  assign accept     = load_valid && !pending_valid;
  // Updates only land on the frame boundary so a frame never mixes old and
  // new digits.
  assign swap       = frame_tick && pending_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_value  <= '0;
      active_blank  <= '0;
      pending_value <= '0;
      pending_blank <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (swap) begin
        active_value <= pending_value;
        active_blank <= pending_blank;
      end
      // accept and swap are exclusive (both need a specific pending_valid),
      // so a load arriving on the frame tick with an empty slot simply waits
      // in pending for the next frame.
      if (accept) begin
        pending_value <= load_value;
        pending_blank <= load_blank;
        pending_valid <= 1'b1;
      end else if (swap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    value_ext                   = '0;
    value_ext[4*N_DIGITS-1:0]   = active_value;
  end

  assign suppress = N_DIGITS'(lzs_mask(value_ext, lzs_en, N_DIGITS));

  // The nibble keeps tracking the scanned digit during blanking so the
  // decoder output is already settled when the enable rises.
  always_comb begin
    cur_nibble = active_value[4*int'(index) +: 4];
    nibble     = cur_nibble;
  end

  always_comb begin
    digit_en = '0;
    if (!in_blank && !active_blank[index] && !suppress[index]) begin
      digit_en[index] = 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles)
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_value;
  logic [3:0]    load_blank;
  logic          lzs_en;
  logic [3:0]    nibble;
  logic [3:0]    digit_en;
  logic          frame_tick;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .N_DIGITS     (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_blank (load_blank),
    .lzs_en     (lzs_en),
    .nibble     (nibble),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0] v;
    logic [3:0]  b;
  } upd_t;

  typedef struct {
    int          start;
    logic [15:0] v;
    logic [3:0]  b;
  } load_t;

  int n_checks = 0;
  int n_pass   = 0;

  upd_t        sb[$];
  load_t       sched[$];
  int          p = 0;
  logic [15:0] m_active;
  logic [3:0]  m_blank;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model to the state it must hold after the coming edge.
  task automatic run_cycle(input int phase, input int t);
    int          slot;
    int          idx;
    logic        ft_exp;
    logic        ready_exp;
    logic        supp;
    logic [3:0]  nib_exp;
    logic [3:0]  en_exp;
    upd_t        u;

    if (p < sched.size() && t >= sched[p].start && phase == 0) begin
      load_valid = 1'b1;
      load_value = sched[p].v;
      load_blank = sched[p].b;
    end else begin
      load_valid = 1'b0;
      load_value = 16'($urandom);
      load_blank = 4'($urandom);
    end
    lzs_en = (phase == 0 && t >= 100 && t < 192);

    slot      = t % RD;
    idx       = (t / RD) % ND;
    ft_exp    = ((t % FRAME) == FRAME - 1);
    ready_exp = (sb.size() == 0);
    nib_exp   = m_active[idx*4 +: 4];
    supp      = lzs_en && idx >= 1 && ((m_active >> (4*idx)) == 16'h0);
    en_exp    = (slot >= BC && !m_blank[idx] && !supp) ? (4'b0001 << idx) : 4'b0000;

    #1;
    check($sformatf("p%0d_digit_en@%0d", phase, t), 32'(digit_en), 32'(en_exp));
    check($sformatf("p%0d_nibble@%0d", phase, t), 32'(nibble), 32'(nib_exp));
    check($sformatf("p%0d_frame_tick@%0d", phase, t), 32'(frame_tick), 32'(ft_exp));
    check($sformatf("p%0d_load_ready@%0d", phase, t), 32'(load_ready), 32'(ready_exp));

    // Hand-derived spot values for the key scenarios.
    if (phase == 0) begin
      if (t == 1)   check("rst_scan_blank", 32'(digit_en), 32'h0);
      if (t == 2)   check("rst_scan_d0", 32'(digit_en), 32'h1);
      if (t == 12)  check("rst_scan_d1", 32'(digit_en), 32'h2);
      if (t == 31)  check("tick31", 32'(frame_tick), 32'h1);
      if (t == 31)  check("busy31", 32'(load_ready), 32'h0);
      if (t == 30)  check("no_tear30", 32'(nibble), 32'h0);
      if (t == 32)  check("ready32", 32'(load_ready), 32'h1);
      if (t == 35)  check("ld_en35", 32'(digit_en), 32'h1);
      if (t == 35)  check("ld_nib35", 32'(nibble), 32'h4);
      if (t == 43)  check("ld_en43", 32'(digit_en), 32'h2);
      if (t == 43)  check("ld_nib43", 32'(nibble), 32'h3);
      if (t == 66)  check("b2b_nib66", 32'(nibble), 32'hD);
      if (t == 96)  check("no_bypass96", 32'(nibble), 32'hD);
      if (t == 128) check("lzs_nib128", 32'(nibble), 32'h0);
      if (t == 138) check("lzs_en138", 32'(digit_en), 32'h2);
      if (t == 138) check("lzs_nib138", 32'(nibble), 32'h5);
      if (t == 146) check("lzs_sup146", 32'(digit_en), 32'h0);
      if (t == 162) check("lzs0_d0_162", 32'(digit_en), 32'h1);
      if (t == 170) check("lzs0_sup170", 32'(digit_en), 32'h0);
      if (t == 204) check("mask_d1_204", 32'(digit_en), 32'h0);
      if (t == 212) check("mask_d2_212", 32'(digit_en), 32'h4);
      if (t == 220) check("mask_d3_220", 32'(digit_en), 32'h8);
    end else begin
      if (t == 2)   check("restart_d0", 32'(digit_en), 32'h1);
      if (t == 63)  check("restart_tick63", 32'(frame_tick), 32'h1);
    end

    if (ft_exp && sb.size() != 0) begin
      u        = sb.pop_front();
      m_active = u.v;
      m_blank  = u.b;
    end
    if (load_valid && ready_exp) begin
      sb.push_back('{v: load_value, b: load_blank});
      p++;
    end
  endtask

  task automatic model_reset();
    m_active = 16'h0;
    m_blank  = 4'h0;
    sb.delete();
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_value = 16'h0;
    load_blank = 4'h0;
    lzs_en     = 1'b0;
    model_reset();

    sched.push_back('{start: 5,   v: 16'h1234, b: 4'b0000});
    sched.push_back('{start: 6,   v: 16'hABCD, b: 4'b0000});
    sched.push_back('{start: 95,  v: 16'h0050, b: 4'b0000});
    sched.push_back('{start: 130, v: 16'h0000, b: 4'b0000});
    sched.push_back('{start: 165, v: 16'h0000, b: 4'b0010});
    sched.push_back('{start: 250, v: 16'hFFFF, b: 4'b0000});

    #2;
    check("reset_digit_en", 32'(digit_en), 32'h0);
    check("reset_nibble", 32'(nibble), 32'h0);
    check("reset_frame_tick", 32'(frame_tick), 32'h0);
    check("reset_load_ready", 32'(load_ready), 32'h1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 252; t++) begin
      run_cycle(0, t);
      @(posedge clk);
      @(negedge clk);
    end

    // Mid-slot (cycle 252) with a pending update outstanding: reset must
    // act without an edge and drop the pending value.
    #1;
    check("pre_rst_ready", 32'(load_ready), 32'h0);
    check("pre_rst_en", 32'(digit_en), 32'h8);
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_en", 32'(digit_en), 32'h0);
    check("async_rst_ready", 32'(load_ready), 32'h1);
    check("async_rst_nibble", 32'(nibble), 32'h0);
    check("async_rst_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int t = 0; t < 70; t++) begin
      run_cycle(1, t);
      @(posedge clk);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
